// File: rtl/capture_read_ctrl.sv
// Triggered capture reader: drains a show-ahead FIFO, waits for a level
// crossing, then streams a fixed-length burst out through a valid/ready port.
//
// Ports:
//   clk_i, rst_i        : clock; asynchronous active-low reset
//   arm_i               : start pulse (IDLE only); latches trigger config
//   trig_rise_i         : 1 = rising crossing, 0 = falling crossing
//   trig_level_i        : unsigned threshold
//   capture_len_i       : burst length incl. trigger sample, 0 = 2^CNT_W
//   fifo_empty_i        : FIFO empty flag
//   fifo_data_i         : FIFO head data
//   fifo_inc_o          : FIFO pop strobe
//   out_data_o          : registered output sample
//   out_valid_o         : output valid, held until out_ready_i
//   out_ready_i         : downstream accept
//   busy_o              : armed or capturing
//   done_o              : one-cycle completion pulse
module capture_read_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              arm_i,
  input  logic              trig_rise_i,
  input  logic [DATA_W-1:0] trig_level_i,
  input  logic [CNT_W-1:0]  capture_len_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  output logic              fifo_inc_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_CAPT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              rise_q, rise_d;
  logic [DATA_W-1:0] level_q, level_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;

  logic pop;
  logic rise_hit;
  logic fall_hit;
  logic trig;

  assign rise_hit = prev_valid_q
                  & (prev_q < level_q)
                  & (fifo_data_i >= level_q);
  assign fall_hit = prev_valid_q
                  & (prev_q > level_q)
                  & (fifo_data_i <= level_q);
  assign trig = rise_q ? rise_hit : fall_hit;

  always_comb begin
    state_d      = state_q;
    rise_d       = rise_q;
    level_d      = level_q;
    len_d        = len_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    pop          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        pop = ~fifo_empty_i;
        if (arm_i) begin
          rise_d       = trig_rise_i;
          level_d      = trig_level_i;
          len_d        = capture_len_i;
          prev_valid_d = 1'b0;
          state_d      = S_ARMED;
        end
      end
      S_ARMED: begin
        pop = ~fifo_empty_i;
        if (pop) begin
          prev_d       = fifo_data_i;
          prev_valid_d = 1'b1;
          if (trig) begin
            out_data_d  = fifo_data_i;
            out_valid_d = 1'b1;
            count_d     = CNT_W'(1);
            state_d     = S_CAPT;
          end
        end
      end
      S_CAPT: begin
        // len 0 means 2^CNT_W: count wraps back to 0 on the last pop
        pop = ~fifo_empty_i
            & (~out_valid_q | out_ready_i)
            & (count_q != len_q);
        if (pop) begin
          out_data_d  = fifo_data_i;
          out_valid_d = 1'b1;
          count_d     = count_q + CNT_W'(1);
        end else if (~out_valid_q | out_ready_i) begin
          out_valid_d = 1'b0;
          if (count_q == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      rise_q       <= 1'b0;
      level_q      <= '0;
      len_q        <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rise_q       <= rise_d;
      level_q      <= level_d;
      len_q        <= len_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign fifo_inc_o  = pop & rst_i;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = (state_q == S_ARMED) | (state_q == S_CAPT);
  assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_capture_read_ctrl.sv
// Directed bench for capture_read_ctrl with a queue-backed show-ahead FIFO.
// Accepted outputs and done pulses are logged and compared to hand values.
module tb_capture_read_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       arm_i;
  logic       trig_rise_i;
  logic [7:0] trig_level_i;
  logic [3:0] capture_len_i;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_inc_o;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic       out_ready_i;
  logic       busy_o;
  logic       done_o;

  capture_read_ctrl #(.DATA_W(8), .CNT_W(4)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .arm_i         (arm_i),
    .trig_rise_i   (trig_rise_i),
    .trig_level_i  (trig_level_i),
    .capture_len_i (capture_len_i),
    .fifo_empty_i  (fifo_empty_i),
    .fifo_data_i   (fifo_data_i),
    .fifo_inc_o    (fifo_inc_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .busy_o        (busy_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  logic [7:0] fq[$];
  logic [7:0] rx[$];
  logic [7:0] exq[$];
  bit         force_empty;
  bit         inc_s;
  int         done_cnt;
  int         errors;
  int         checks;
  int         d0;
  int         n;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty_i = force_empty || (fq.size() == 0);
    fifo_data_i  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  // One clock: sample before the edge, pop the model FIFO on the edge.
  task automatic cyc();
    drive_fifo();
    #1;
    chk("inc_while_empty", {31'b0, fifo_inc_o & fifo_empty_i}, 0);
    if (out_valid_o && out_ready_i) rx.push_back(out_data_o);
    if (done_o) done_cnt++;
    inc_s = fifo_inc_o;
    @(posedge clk_i);
    if (inc_s && fq.size() != 0) void'(fq.pop_front());
    #1;
    drive_fifo();
    #1;
  endtask

  task automatic arm(input bit rise, input logic [7:0] lvl,
                     input logic [3:0] len);
    trig_rise_i   = rise;
    trig_level_i  = lvl;
    capture_len_i = len;
    arm_i         = 1'b1;
    cyc();
    arm_i         = 1'b0;
  endtask

  task automatic finish_capture(input string tag, input int maxc);
    int k;
    int s;
    s = done_cnt;
    k = 0;
    while (done_cnt == s && k < maxc) begin
      cyc();
      k++;
    end
    chk({tag, "_done_seen"}, done_cnt - s, 1);
    repeat (3) cyc();
    chk({tag, "_done_once"}, done_cnt - s, 1);
    chk({tag, "_busy_low"}, {31'b0, busy_o}, 0);
  endtask

  task automatic chk_rx(input string tag);
    chk({tag, "_count"}, rx.size(), exq.size());
    for (int i = 0; i < exq.size() && i < rx.size(); i++)
      chk($sformatf("%s_s%0d", tag, i), rx[i], exq[i]);
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    done_cnt      = 0;
    force_empty   = 1'b0;
    rst_i         = 1'b0;
    arm_i         = 1'b0;
    trig_rise_i   = 1'b1;
    trig_level_i  = 8'h00;
    capture_len_i = 4'd0;
    out_ready_i   = 1'b1;
    fq            = {8'h55};
    drive_fifo();

    // reset state, with a non-empty FIFO present
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    chk("rst_valid", {31'b0, out_valid_o}, 0);
    chk("rst_data", {24'b0, out_data_o}, 0);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_done", {31'b0, done_o}, 0);
    chk("rst_inc", {31'b0, fifo_inc_o}, 0);
    rst_i = 1'b1;
    #1;
    chk("idle_flush_inc", {31'b0, fifo_inc_o}, 1);
    repeat (2) cyc();
    chk("idle_flushed", fq.size(), 0);

    // rising trigger, len 4
    rx.delete();
    arm(1'b1, 8'h80, 4'd4);
    chk("rise_busy", {31'b0, busy_o}, 1);
    fq = {8'h10, 8'h20, 8'h7F, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
    finish_capture("rise", 40);
    exq = {8'h80, 8'h90, 8'hA0, 8'hB0};
    chk_rx("rise");
    chk("rise_tail_flushed", fq.size(), 0);

    // falling trigger, first sample must not fire
    rx.delete();
    arm(1'b0, 8'h40, 4'd1);
    fq = {8'h30, 8'h50, 8'h40};
    finish_capture("fall", 30);
    exq = {8'h40};
    chk_rx("fall");

    // backpressure
    rx.delete();
    out_ready_i = 1'b0;
    arm(1'b1, 8'h80, 4'd4);
    fq = {8'h00, 8'h80, 8'h81, 8'h82, 8'h83};
    n = 0;
    while (!out_valid_o && n < 20) begin
      cyc();
      n++;
    end
    chk("bp_trig", {31'b0, out_valid_o}, 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk($sformatf("bp_inc_%0d", i), {31'b0, fifo_inc_o}, 0);
      chk($sformatf("bp_data_%0d", i), {24'b0, out_data_o}, 32'h80);
      chk($sformatf("bp_valid_%0d", i), {31'b0, out_valid_o}, 1);
    end
    out_ready_i = 1'b1;
    finish_capture("bp", 40);
    exq = {8'h80, 8'h81, 8'h82, 8'h83};
    chk_rx("bp");
    chk("bp_fifo_drained", fq.size(), 0);

    // len 0 with CNT_W 4 -> 16 samples
    rx.delete();
    arm(1'b1, 8'h80, 4'd0);
    fq = {8'h00};
    exq.delete();
    for (int i = 0; i < 16; i++) begin
      fq.push_back(8'h80 + 8'(i));
      exq.push_back(8'h80 + 8'(i));
    end
    fq.push_back(8'h90);
    fq.push_back(8'h91);
    finish_capture("len0", 80);
    chk_rx("len0");

    // reset in the middle of a capture
    rx.delete();
    arm(1'b1, 8'h80, 4'd4);
    fq = {8'h00, 8'h80, 8'h81, 8'h82, 8'h83};
    d0 = done_cnt;
    n = 0;
    while (rx.size() < 2 && n < 20) begin
      cyc();
      n++;
    end
    chk("mid_rx2", rx.size(), 2);
    chk("mid_valid_pre", {31'b0, out_valid_o}, 1);
    chk("mid_fifo_left", {31'b0, fifo_empty_i}, 0);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid_o}, 0);
    chk("mid_rst_busy", {31'b0, busy_o}, 0);
    chk("mid_rst_inc", {31'b0, fifo_inc_o}, 0);
    chk("mid_rst_data", {24'b0, out_data_o}, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) cyc();
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_idle_busy", {31'b0, busy_o}, 0);
    rx.delete();
    arm(1'b1, 8'h80, 4'd2);
    fq = {8'h10, 8'h90, 8'h91};
    finish_capture("rearm", 30);
    exq = {8'h90, 8'h91};
    chk_rx("rearm");

    // empty FIFO while armed; arm ignored when busy
    rx.delete();
    force_empty = 1'b1;
    fq = {8'h00, 8'h80, 8'h81};
    arm(1'b1, 8'h80, 4'd2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        trig_rise_i   = 1'b0;
        trig_level_i  = 8'h10;
        capture_len_i = 4'd5;
        arm_i         = 1'b1;
      end
      cyc();
      arm_i = 1'b0;
      chk($sformatf("empty_inc_%0d", i), {31'b0, fifo_inc_o}, 0);
      chk($sformatf("empty_busy_%0d", i), {31'b0, busy_o}, 1);
    end
    chk("empty_untouched", fq.size(), 3);
    chk("empty_no_out", rx.size(), 0);
    force_empty = 1'b0;
    finish_capture("empty", 30);
    exq = {8'h80, 8'h81};
    chk_rx("empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_read_ctrl.md
CAPTURE_READ_CTRL -- requirements
Module: capture_read_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, sample width in bits.
REQ-002 Parameter CNT_W, default 8, capture-length counter width.
REQ-003 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 arm_i  input  1  one-cycle pulse; starts a capture from IDLE.
REQ-006 trig_rise_i  input  1  1 = rising-edge trigger, 0 = falling-edge trigger; sampled at arm.
REQ-007 trig_level_i  input  DATA_W  unsigned trigger threshold; sampled at arm.
REQ-008 capture_len_i  input  CNT_W  samples to emit, including the trigger sample; 0 means 2^CNT_W; sampled at arm.
REQ-009 fifo_empty_i  input  1  FIFO read-side empty flag.
REQ-010 fifo_data_i  input  DATA_W  show-ahead FIFO read data, valid whenever fifo_empty_i = 0.
REQ-011 fifo_inc_o  output  1  FIFO pop strobe; the current sample is consumed at the clock edge.
REQ-012 out_data_o  output  DATA_W  captured sample, registered.
REQ-013 out_valid_o  output  1  out_data_o valid; held until accepted.
REQ-014 out_ready_i  input  1  downstream accept; transfer when out_valid_o & out_ready_i.
REQ-015 busy_o  output  1  high in ARMED and CAPTURE.
REQ-016 done_o  output  1  one-cycle pulse when the capture completes.

Function
REQ-017 The FSM SHALL have four states: IDLE, ARMED, CAPTURE, DONE.
REQ-018 IDLE: fifo_inc_o = ~fifo_empty_i, flushing stale samples; arm_i latches trig_rise_i, trig_level_i and capture_len_i, clears prev_valid, and moves to ARMED.
REQ-019 ARMED: fifo_inc_o = ~fifo_empty_i; each popped sample updates the prev register and sets prev_valid.
REQ-020 Rising trigger SHALL be prev_valid & (prev < level) & (cur >= level); falling trigger SHALL be prev_valid & (prev > level) & (cur <= level); comparisons are unsigned.
REQ-021 The first sample after arm SHALL never trigger, because prev_valid = 0.
REQ-022 On the trigger edge, the trigger sample SHALL load out_data_o, out_valid_o is set, count becomes 1, and the state moves to CAPTURE.
REQ-023 CAPTURE: fifo_inc_o = ~fifo_empty_i & (~out_valid_o | out_ready_i) & (count != len); every pop loads out_data_o, sets out_valid_o and increments count.
REQ-024 An accept with no pop in the same cycle SHALL clear out_valid_o; an accept with a pop keeps it high with new data, giving full throughput.
REQ-025 When count == len and the final sample is accepted, the state SHALL move to DONE. len = 2^CNT_W is represented as count wrapping to 0 after the last pop.
REQ-026 DONE lasts one cycle: done_o = 1, fifo_inc_o = 0, then return to IDLE.
REQ-027 arm_i SHALL be ignored outside IDLE; arm_i in the DONE cycle is also ignored.
REQ-028 fifo_inc_o SHALL never be asserted while fifo_empty_i = 1.
REQ-029 out_data_o SHALL NOT change while out_valid_o & ~out_ready_i.
REQ-030 An empty FIFO in ARMED or CAPTURE SHALL stall the FSM without a state change; there is no timeout.

Reset
REQ-031 Asserting rst_i low SHALL immediately force: state IDLE; out_valid_o 0; out_data_o 0; done_o 0; busy_o 0; count 0; prev_valid 0; and latched configuration 0.
REQ-032 Reset SHALL abort any capture in progress; no done_o is produced for an aborted capture, and the first post-reset cycle is in IDLE.
REQ-033 fifo_inc_o SHALL be 0 while rst_i is low.

Verification
REQ-034 Rising trigger: arm with level = 0x80, len = 4; feed samples 10,20,7F,80,90,A0,B0,C0 with out_ready_i = 1 -> out emits 80,90,A0,B0, then done_o pulses once and busy_o falls.
REQ-035 Falling trigger with first-sample guard: arm with trig_rise_i = 0, level = 0x40; feed 30,50,40 -> the trigger fires on 40 (prev 50), not on 30.
REQ-036 Backpressure: CAPTURE with out_ready_i held low for 5 cycles -> fifo_inc_o stays 0 and out_data_o is stable; after release, no sample is lost or duplicated.
REQ-037 len = 0 with CNT_W = 4 -> exactly 16 samples emitted before done_o.
REQ-038 Reset mid-CAPTURE after 2 of 4 samples -> out_valid_o = 0 immediately and state returns to IDLE with no done_o; a re-arm captures normally.
REQ-039 Empty FIFO: fifo_empty_i = 1 throughout ARMED -> fifo_inc_o = 0 and no trigger; arm_i pulses while busy are ignored.
